bubble_host_sequencer: RTL

- Synthesizable host-side sequencer that drives the bubble drive control strobes (nBSEN, nREPEN, nBOOTEN) and captures returned data.
- Parametrised successor of the hand-timed bench stimulus: boot-loop and page-read sequences are command driven, timing is parameter driven, and data-channel count is configurable.
- Used as the self-test host in front of BubbleDrive8_top, in simulation and in the on-board loopback build.

---
 rtl/bubble_host_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/bubble_host_sequencer.sv
// Host-side bubble drive sequencer: command-driven boot-loop / page-read strobe
// generation on nBSEN/nREPEN/nBOOTEN with periodic DOUT capture.
module bubble_host_sequencer #(
  parameter int unsigned      CHANNELS       = 2,
  parameter int unsigned      CNT_W          = 24,
  parameter logic [CNT_W-1:0] SETUP_CYC      = CNT_W'(50000),
  parameter logic [CNT_W-1:0] BOOT_REP_DLY   = CNT_W'(38),
  parameter logic [CNT_W-1:0] REP_LOW_CYC    = CNT_W'(1233),
  parameter logic [CNT_W-1:0] REP_HIGH_CYC   = CNT_W'(687),
  parameter logic [CNT_W-1:0] BOOT_SHIFT_CYC = CNT_W'(4387745),
  parameter logic [CNT_W-1:0] BOOT_TAIL_CYC  = CNT_W'(423),
  parameter logic [CNT_W-1:0] PAGE_SHIFT_CYC = CNT_W'(675660),
  parameter logic [CNT_W-1:0] PAGE_REP_OFS   = CNT_W'(600000),
  parameter logic [CNT_W-1:0] REP_PULSE_CYC  = CNT_W'(683),
  parameter logic [CNT_W-1:0] BIT_CYC        = CNT_W'(16)
) (
  input  logic                MCLK,
  input  logic                MRST,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_boot,
  input  logic                cmd_abort,
  output logic                nBSEN,
  output logic                nREPEN,
  output logic                nBOOTEN,
  input  logic [CHANNELS-1:0] DOUT,
  output logic                bit_valid,
  output logic [CHANNELS-1:0] bit_data,
  output logic [15:0]         bit_count,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, TAIL} state_t;

  state_t           state;
  logic             boot;
  logic             rep_on;
  logic             samp_en;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] ph_cnt;
  logic [CNT_W-1:0] bit_tmr;
  logic [CNT_W-1:0] cnt_nxt;
  logic             shift_last;
  logic             rep_start;
  logic             rep_flip;
  logic             sample_due;

  // cnt holds the zero-based cycle index within the current state; nREPEN
  // decisions look at the index of the cycle about to start (cnt_nxt).
  always_comb begin
    cnt_nxt    = cnt + 1'b1;
    shift_last = boot ? (cnt == BOOT_SHIFT_CYC - 1'b1) : (cnt == PAGE_SHIFT_CYC - 1'b1);
    rep_start  = !rep_on && (boot ? (cnt_nxt == BOOT_REP_DLY) : (cnt_nxt == PAGE_REP_OFS));
    rep_flip   = 1'b0;
    if (rep_on) begin
      if (boot)
        rep_flip = nREPEN ? (ph_cnt == REP_HIGH_CYC - 1'b1) : (ph_cnt == REP_LOW_CYC - 1'b1);
      else
        rep_flip = !nREPEN && (ph_cnt == REP_PULSE_CYC - 1'b1);
    end
    sample_due = samp_en && (bit_tmr == BIT_CYC - 1'b1);
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge MCLK) begin
    if (!MRST) begin
      state     <= IDLE;
      nBSEN     <= 1'b1;
      nREPEN    <= 1'b1;
      nBOOTEN   <= 1'b1;
      boot      <= 1'b0;
      rep_on    <= 1'b0;
      samp_en   <= 1'b0;
      cnt       <= '0;
      ph_cnt    <= '0;
      bit_tmr   <= '0;
      bit_valid <= 1'b0;
      bit_data  <= '0;
      bit_count <= '0;
      done      <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      done      <= 1'b0;
      if (state != IDLE && cmd_abort) begin
        state   <= IDLE;
        nBSEN   <= 1'b1;
        nREPEN  <= 1'b1;
        nBOOTEN <= 1'b1;
        rep_on  <= 1'b0;
        samp_en <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_valid) begin
              state     <= SETUP;
              boot      <= cmd_boot;
              nBOOTEN   <= !cmd_boot;
              cnt       <= '0;
              bit_count <= '0;
            end
          end
          SETUP: begin
            if (cnt == SETUP_CYC - 1'b1) begin
              state <= SHIFT;
              cnt   <= '0;
              nBSEN <= 1'b0;
              if (boot && BOOT_REP_DLY == '0) begin
                nREPEN  <= 1'b0;
                rep_on  <= 1'b1;
                ph_cnt  <= '0;
                samp_en <= 1'b1;
                bit_tmr <= '0;
              end
            end else begin
              cnt <= cnt_nxt;
            end
          end
          SHIFT: begin
            if (samp_en) begin
              if (sample_due) begin
                bit_tmr   <= '0;
                bit_data  <= DOUT;
                bit_valid <= 1'b1;
                if (bit_count != 16'hFFFF) bit_count <= bit_count + 16'd1;
              end else begin
                bit_tmr <= bit_tmr + 1'b1;
              end
            end
            // Shift end wins over any nREPEN phase change, truncating a pulse.
            if (shift_last) begin
              nBSEN   <= 1'b1;
              nREPEN  <= 1'b1;
              rep_on  <= 1'b0;
              samp_en <= 1'b0;
              cnt     <= '0;
              if (boot) begin
                state <= TAIL;
              end else begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end else begin
              cnt <= cnt_nxt;
              if (rep_start) begin
                nREPEN  <= 1'b0;
                rep_on  <= 1'b1;
                ph_cnt  <= '0;
                samp_en <= 1'b1;
                bit_tmr <= '0;
              end else if (rep_on) begin
                if (rep_flip) begin
                  nREPEN <= !nREPEN;
                  ph_cnt <= '0;
                end else begin
                  ph_cnt <= ph_cnt + 1'b1;
                end
              end
            end
          end
          TAIL: begin
            if (cnt == BOOT_TAIL_CYC - 1'b1) begin
              state   <= IDLE;
              nBOOTEN <= 1'b1;
              done    <= 1'b1;
            end else begin
              cnt <= cnt_nxt;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
